// File: rtl/key_anim_engine.sv
// Per-key animation engine for the rhythm-game canvas: one key is advanced per cycle
// in a frame-triggered sweep, with Avalon-MM control/counters and a 1-cycle render port.
module key_anim_engine #(
    parameter int NKEYS       = 51,
    parameter int NSIZE_W     = 3,
    parameter int BRGHT_W     = 3,
    parameter int GROW_DIV    = 4,
    parameter int FADE_DIV    = 2,
    parameter int HOLD_FRAMES = 8,
    parameter int FAR_MIN     = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [NKEYS-1:0]              key_touch,
    input  logic                          avl_cs,
    input  logic                          avl_rden,
    input  logic                          avl_wren,
    input  logic [5:0]                    avl_addr,
    input  logic [7:0]                    avl_wdata,
    output logic [7:0]                    avl_rdata,
    input  logic [5:0]                    rd_idx,
    output logic [BRGHT_W+2+NSIZE_W-1:0]  rd_keystat,
    output logic                          judge_valid,
    output logic [5:0]                    judge_key,
    output logic [1:0]                    judge_result
);

    localparam int SUB_MAX0 = (GROW_DIV > HOLD_FRAMES) ? GROW_DIV : HOLD_FRAMES;
    localparam int SUB_MAX  = (SUB_MAX0 > FADE_DIV) ? SUB_MAX0 : FADE_DIV;
    localparam int SUB_W    = (SUB_MAX > 2) ? $clog2(SUB_MAX) : 1;

    localparam logic [NSIZE_W-1:0] NSIZE_MAX = '1;
    localparam logic [BRGHT_W-1:0] BRGHT_MAX = '1;
    localparam logic [NSIZE_W-1:0] FAR_NS    = NSIZE_W'(FAR_MIN);
    localparam logic [SUB_W-1:0]   GROW_LAST = SUB_W'(GROW_DIV - 1);
    localparam logic [SUB_W-1:0]   HOLD_LAST = SUB_W'(HOLD_FRAMES - 1);
    localparam logic [SUB_W-1:0]   FADE_LAST = SUB_W'(FADE_DIV - 1);
    localparam logic [5:0]         NKEYS_IDX = 6'(NKEYS);
    localparam logic [5:0]         LAST_IDX  = 6'(NKEYS - 1);
    localparam logic [7:0]         NKEYS_WD  = 8'(NKEYS);
    localparam logic [NKEYS-1:0]   ONE_K     = NKEYS'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GROW = 2'd1;
    localparam logic [1:0] ST_EXIT = 2'd2;
    localparam logic [1:0] ST_GLOW = 2'd3;

    localparam logic [1:0] JR_LOST = 2'd1;
    localparam logic [1:0] JR_FAR  = 2'd2;
    localparam logic [1:0] JR_PURE = 2'd3;

    logic [1:0]         st_mem [NKEYS];
    logic [NSIZE_W-1:0] ns_mem [NKEYS];
    logic [BRGHT_W-1:0] br_mem [NKEYS];
    logic [1:0]         co_mem [NKEYS];
    logic [SUB_W-1:0]   sb_mem [NKEYS];

    logic [NKEYS-1:0] touch_prev, touch_pend, launch_pend;
    logic [NKEYS-1:0] sweep_mask, launch_set;
    logic             busy;
    logic [5:0]       idx;
    logic [15:0]      npure, nfar, nlost, ncombo;
    logic             st_overrun, st_reject;
    logic [7:0]       rd_mux;

    logic               cur_touch, cur_launch, moved;
    logic [1:0]         cur_st, nx_st, nx_co, cur_co, nx_jres;
    logic [NSIZE_W-1:0] cur_ns, nx_ns;
    logic [BRGHT_W-1:0] cur_br, nx_br;
    logic [SUB_W-1:0]   cur_sb, nx_sb;
    logic               nx_judge, nx_reject;

    logic wr, launch_wr, clr_wr, stat_wr;

    assign wr        = avl_cs & avl_wren;
    assign launch_wr = wr && (avl_addr == 6'h00) && (avl_wdata < NKEYS_WD);
    assign stat_wr   = wr && (avl_addr == 6'h01);
    assign clr_wr    = wr && (avl_addr == 6'h0A);

    assign launch_set = launch_wr ? (ONE_K << avl_wdata) : '0;
    assign sweep_mask = busy ? (ONE_K << idx) : '0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next state of the key under the sweep pointer: touch, then timers, then launch.
    always_comb begin
        cur_st     = st_mem[idx];
        cur_ns     = ns_mem[idx];
        cur_br     = br_mem[idx];
        cur_co     = co_mem[idx];
        cur_sb     = sb_mem[idx];
        cur_touch  = touch_pend[idx];
        cur_launch = launch_pend[idx];
        nx_st      = cur_st;
        nx_ns      = cur_ns;
        nx_br      = cur_br;
        nx_co      = cur_co;
        nx_sb      = cur_sb;
        nx_judge   = 1'b0;
        nx_jres    = 2'd0;
        nx_reject  = 1'b0;
        moved      = 1'b0;

        if (cur_touch) begin
            if (cur_st == ST_IDLE || cur_st == ST_GLOW) begin
                nx_st = ST_GLOW;
                nx_br = BRGHT_MAX;
                nx_co = 2'd0;
                nx_ns = '0;
                nx_sb = '0;
                moved = 1'b1;
            end else if (cur_st == ST_GROW && cur_ns >= FAR_NS) begin
                nx_st    = ST_EXIT;
                nx_co    = (cur_ns == NSIZE_MAX) ? JR_PURE : JR_FAR;
                nx_br    = BRGHT_MAX;
                nx_sb    = '0;
                nx_judge = 1'b1;
                nx_jres  = (cur_ns == NSIZE_MAX) ? JR_PURE : JR_FAR;
                moved    = 1'b1;
            end
        end

        if (!moved) begin
            if (cur_st == ST_GROW) begin
                if (cur_ns == NSIZE_MAX) begin
                    if (cur_sb == HOLD_LAST) begin
                        nx_st    = ST_EXIT;
                        nx_co    = JR_LOST;
                        nx_br    = BRGHT_MAX;
                        nx_sb    = '0;
                        nx_judge = 1'b1;
                        nx_jres  = JR_LOST;
                    end else begin
                        nx_sb = cur_sb + 1'b1;
                    end
                end else if (cur_sb == GROW_LAST) begin
                    nx_ns = cur_ns + 1'b1;
                    nx_sb = '0;
                end else begin
                    nx_sb = cur_sb + 1'b1;
                end
            end else if (cur_st == ST_GLOW || cur_st == ST_EXIT) begin
                if (cur_sb == FADE_LAST) begin
                    nx_sb = '0;
                    if (cur_br <= BRGHT_W'(1)) begin
                        nx_st = ST_IDLE;
                        nx_ns = '0;
                        nx_br = '0;
                        nx_co = 2'd0;
                    end else begin
                        nx_br = cur_br - 1'b1;
                    end
                end else begin
                    nx_sb = cur_sb + 1'b1;
                end
            end
        end

        if (cur_launch) begin
            if (nx_st == ST_IDLE || nx_st == ST_GLOW) begin
                nx_st = ST_GROW;
                nx_ns = NSIZE_W'(1);
                nx_co = 2'd0;
                nx_br = BRGHT_MAX;
                nx_sb = '0;
            end else begin
                nx_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NKEYS; i++) begin
                st_mem[i] <= ST_IDLE;
                ns_mem[i] <= '0;
                br_mem[i] <= '0;
                co_mem[i] <= '0;
                sb_mem[i] <= '0;
            end
        end else if (busy) begin
            st_mem[idx] <= nx_st;
            ns_mem[idx] <= nx_ns;
            br_mem[idx] <= nx_br;
            co_mem[idx] <= nx_co;
            sb_mem[idx] <= nx_sb;
        end
    end

    // New events OR in after the sweep clear so an event landing on its own sweep cycle survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            touch_prev  <= '0;
            touch_pend  <= '0;
            launch_pend <= '0;
        end else begin
            touch_prev  <= key_touch;
            touch_pend  <= (touch_pend & ~sweep_mask) | (key_touch & ~touch_prev);
            launch_pend <= (launch_pend & ~sweep_mask) | launch_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            idx  <= '0;
        end else if (busy) begin
            if (idx == LAST_IDX) begin
                busy <= 1'b0;
                idx  <= '0;
            end else begin
                idx <= idx + 6'd1;
            end
        end else if (frame_tick) begin
            busy <= 1'b1;
            idx  <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_overrun <= 1'b0;
            st_reject  <= 1'b0;
        end else begin
            if (stat_wr && avl_wdata[1]) st_reject <= 1'b0;
            if (stat_wr && avl_wdata[2]) st_overrun <= 1'b0;
            if (busy && nx_reject) st_reject <= 1'b1;
            if (busy && frame_tick) st_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            npure  <= '0;
            nfar   <= '0;
            nlost  <= '0;
            ncombo <= '0;
        end else if (clr_wr) begin
            npure  <= '0;
            nfar   <= '0;
            nlost  <= '0;
            ncombo <= '0;
        end else if (busy && nx_judge) begin
            case (nx_jres)
                JR_PURE: begin
                    npure  <= sat_inc(npure);
                    ncombo <= sat_inc(ncombo);
                end
                JR_FAR: begin
                    nfar   <= sat_inc(nfar);
                    ncombo <= sat_inc(ncombo);
                end
                JR_LOST: begin
                    nlost  <= sat_inc(nlost);
                    ncombo <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            judge_valid  <= 1'b0;
            judge_key    <= '0;
            judge_result <= '0;
        end else begin
            judge_valid  <= busy & nx_judge;
            judge_key    <= (busy & nx_judge) ? idx : '0;
            judge_result <= (busy & nx_judge) ? nx_jres : '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avl_addr)
            6'h01:   rd_mux = {5'b0, st_overrun, st_reject, busy};
            6'h02:   rd_mux = npure[7:0];
            6'h03:   rd_mux = npure[15:8];
            6'h04:   rd_mux = nfar[7:0];
            6'h05:   rd_mux = nfar[15:8];
            6'h06:   rd_mux = nlost[7:0];
            6'h07:   rd_mux = nlost[15:8];
            6'h08:   rd_mux = ncombo[7:0];
            6'h09:   rd_mux = ncombo[15:8];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avl_rdata <= '0;
        end else if (avl_cs && avl_rden) begin
            avl_rdata <= rd_mux;
        end else begin
            avl_rdata <= '0;
        end
    end

    // Forward the in-flight sweep result so the renderer never sees a stale key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_keystat <= '0;
        end else if (rd_idx >= NKEYS_IDX) begin
            rd_keystat <= '0;
        end else if (busy && rd_idx == idx) begin
            rd_keystat <= {nx_br, nx_co, nx_ns};
        end else begin
            rd_keystat <= {br_mem[rd_idx], co_mem[rd_idx], ns_mem[rd_idx]};
        end
    end

endmodule

// File: tb/tb_key_anim_engine.sv
// Directed bench for key_anim_engine: grow/judge/fade sequences, status, counters, reset.
module tb_key_anim_engine;

    localparam int NKEYS = 51;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             frame_tick = 1'b0;
    logic [NKEYS-1:0] key_touch = '0;
    logic             avl_cs = 1'b0;
    logic             avl_rden = 1'b0;
    logic             avl_wren = 1'b0;
    logic [5:0]       avl_addr = '0;
    logic [7:0]       avl_wdata = '0;
    logic [7:0]       avl_rdata;
    logic [5:0]       rd_idx = '0;
    logic [7:0]       rd_keystat;
    logic             judge_valid;
    logic [5:0]       judge_key;
    logic [1:0]       judge_result;

    key_anim_engine #(
        .NKEYS(NKEYS), .NSIZE_W(3), .BRGHT_W(3), .GROW_DIV(4),
        .FADE_DIV(2), .HOLD_FRAMES(8), .FAR_MIN(5)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .key_touch(key_touch),
        .avl_cs(avl_cs), .avl_rden(avl_rden), .avl_wren(avl_wren),
        .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_rdata(avl_rdata),
        .rd_idx(rd_idx), .rd_keystat(rd_keystat),
        .judge_valid(judge_valid), .judge_key(judge_key), .judge_result(judge_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int jcnt = 0;
    logic [5:0] jkey = '0;
    logic [1:0] jres = '0;

    always @(negedge clk) begin
        if (judge_valid) begin
            jcnt++;
            jkey = judge_key;
            jres = judge_result;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            repeat (NKEYS + 1) @(negedge clk);
        end
    endtask

    task automatic touch(input int k);
        @(negedge clk) key_touch[k] = 1'b1;
        @(negedge clk) key_touch[k] = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        avl_cs = 1'b1; avl_wren = 1'b1; avl_addr = a; avl_wdata = d;
        @(negedge clk);
        avl_cs = 1'b0; avl_wren = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        avl_cs = 1'b1; avl_rden = 1'b1; avl_addr = a;
        @(negedge clk);
        avl_cs = 1'b0; avl_rden = 1'b0;
        d = avl_rdata;
    endtask

    task automatic rd16(input logic [5:0] a, output logic [15:0] d);
        logic [7:0] lo, hi;
        rd(a, lo);
        rd(a + 6'd1, hi);
        d = {hi, lo};
    endtask

    task automatic ks(input int k, output logic [7:0] d);
        @(negedge clk) rd_idx = 6'(k);
        @(negedge clk) d = rd_keystat;
    endtask

    initial begin
        logic [7:0]  d8;
        logic [15:0] d16;
        int bad;

        repeat (3) @(negedge clk);
        check("rst_judge_valid", 16'(judge_valid), 16'd0);
        check("rst_keystat", 16'(rd_keystat), 16'd0);
        check("rst_rdata", 16'(avl_rdata), 16'd0);
        reset = 1'b0;
        rd(6'h01, d8);   check("rst_status", 16'(d8), 16'h00);

        // PURE on key 3
        wr(6'h00, 8'd3);
        frames(1);
        ks(3, d8);       check("k3_launch", 16'(d8), 16'hE1);
        frames(24);
        ks(3, d8);       check("k3_at_max", 16'(d8), 16'hE7);
        touch(3);
        frames(1);
        check("k3_jcnt", 16'(jcnt), 16'd1);
        check("k3_jkey", 16'(jkey), 16'd3);
        check("k3_jres", 16'(jres), 16'd3);
        ks(3, d8);       check("k3_pure_ks", 16'(d8), 16'hFF);
        rd16(6'h02, d16); check("npure_1", d16, 16'd1);
        rd16(6'h08, d16); check("ncombo_1", d16, 16'd1);

        // LOST on key 0
        wr(6'h00, 8'd0);
        frames(32);
        check("k0_no_early_lost", 16'(jcnt), 16'd1);
        frames(1);
        check("k0_jcnt", 16'(jcnt), 16'd2);
        check("k0_jkey", 16'(jkey), 16'd0);
        check("k0_jres", 16'(jres), 16'd1);
        ks(0, d8);       check("k0_lost_ks", 16'(d8), 16'hEF);
        ks(3, d8);       check("k3_faded", 16'(d8), 16'h00);
        rd16(6'h06, d16); check("nlost_1", d16, 16'd1);
        rd16(6'h08, d16); check("ncombo_0", d16, 16'd0);
        frames(13);
        ks(0, d8);       check("k0_fade_b1", 16'(d8), 16'h2F);
        frames(1);
        ks(0, d8);       check("k0_idle", 16'(d8), 16'h00);

        // Empty-touch glow on key 10
        touch(10);
        frames(1);
        ks(10, d8);      check("k10_glow", 16'(d8), 16'hE0);
        frames(2);
        ks(10, d8);      check("k10_fade", 16'(d8), 16'hC0);
        frames(12);
        ks(10, d8);      check("k10_idle", 16'(d8), 16'h00);
        check("k10_no_judge", 16'(jcnt), 16'd2);

        // FAR on key 5, with early touches ignored
        wr(6'h00, 8'd5);
        frames(1);
        frames(8);
        ks(5, d8);       check("k5_ns3", 16'(d8), 16'hE3);
        touch(5);
        frames(1);
        ks(5, d8);       check("k5_touch_ns3", 16'(d8), 16'hE3);
        frames(6);
        ks(5, d8);       check("k5_ns4", 16'(d8), 16'hE4);
        touch(5);
        frames(1);
        ks(5, d8);       check("k5_touch_ns4", 16'(d8), 16'hE5);
        check("k5_no_judge", 16'(jcnt), 16'd2);
        touch(5);
        frames(1);
        ks(5, d8);       check("k5_far_ks", 16'(d8), 16'hF5);
        check("k5_jcnt", 16'(jcnt), 16'd3);
        check("k5_jkey", 16'(jkey), 16'd5);
        check("k5_jres", 16'(jres), 16'd2);
        rd16(6'h04, d16); check("nfar_1", d16, 16'd1);
        rd16(6'h08, d16); check("ncombo_far", d16, 16'd1);

        // Launch reject and overrun status
        wr(6'h00, 8'd7);
        frames(1);
        wr(6'h00, 8'd7);
        frames(1);
        rd(6'h01, d8);   check("stat_reject", 16'(d8), 16'h02);
        wr(6'h01, 8'h02);
        rd(6'h01, d8);   check("stat_rej_clr", 16'(d8), 16'h00);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (6) @(negedge clk);
        rd(6'h01, d8);   check("stat_busy", 16'(d8), 16'h01);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (NKEYS + 2) @(negedge clk);
        rd(6'h01, d8);   check("stat_overrun", 16'(d8), 16'h04);
        wr(6'h01, 8'h04);
        rd(6'h01, d8);   check("stat_ovr_clr", 16'(d8), 16'h00);
        rd(6'h0B, d8);   check("unmapped", 16'(d8), 16'h00);
        ks(63, d8);      check("ks_oob", 16'(d8), 16'h00);

        // Reset in the middle of a sweep
        touch(30);
        frames(1);
        ks(30, d8);      check("k30_glow", 16'(d8), 16'hE0);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_jv", 16'(judge_valid), 16'd0);
        check("mid_rst_ks", 16'(rd_keystat), 16'd0);
        check("mid_rst_rdata", 16'(avl_rdata), 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < NKEYS; k++) begin
            ks(k, d8);
            if (d8 != 8'h00) bad++;
        end
        check("post_rst_all_ks", 16'(bad), 16'd0);
        rd16(6'h02, d16); check("post_rst_npure", d16, 16'd0);
        rd16(6'h04, d16); check("post_rst_nfar", d16, 16'd0);
        rd16(6'h06, d16); check("post_rst_nlost", d16, 16'd0);
        rd(6'h01, d8);    check("post_rst_status", 16'(d8), 16'h00);

        // Counter clear
        wr(6'h00, 8'd1);
        frames(25);
        touch(1);
        frames(1);
        check("k1_jres", 16'(jres), 16'd3);
        rd16(6'h02, d16); check("npure_pre_clr", d16, 16'd1);
        wr(6'h0A, 8'h00);
        rd16(6'h02, d16); check("npure_clr", d16, 16'd0);
        rd16(6'h08, d16); check("ncombo_clr", d16, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
